reg_scoreboard: RTL and testbench

Per-register write-pending scoreboard that sequences issue from the ID stage into the ARM pipeline. It counts in-flight register-file writes (EXE/MEM/WB) for each of the 16 architectural registers and retires them on WB write-back. It drives the `hazard` input of the ID stage, which zeroes the control word and holds IF/ID. It replaces a stateless stage-by-stage comparator, and also reports total outstanding writes and a sticky consistency error.

---
 rtl/reg_scoreboard.sv | 106 ++++++++++
 tb/tb_reg_scoreboard.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Per-register write-pending scoreboard feeding the ID-stage hazard (optional SB_FORWARDING_EN: load-use-only source stall).
// Latency: hazard is combinational; counters, pending_cnt and sb_error update one cycle after accept/retire.
// Backpressure: hazard stalls ID; freeze holds all state; flush squashes the ID instruction without touching counters.
module reg_scoreboard #(
    parameter int unsigned MAX_PEND = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic       issue_wb_en,
    input  logic [3:0] issue_dest,
    input  logic       issue_is_load,
    input  logic [3:0] src1,
    input  logic       src1_en,
    input  logic [3:0] src2,
    input  logic       two_src,
    input  logic       freeze,
    input  logic       flush,
    input  logic       wb_en,
    input  logic [3:0] dest_wb,
    output logic       hazard,
    output logic [5:0] pending_cnt,
    output logic       sb_error
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_PEND);

    logic [1:0] cnt [16];
    logic       load_v_q;
    logic [3:0] load_dest_q;

    logic accept;
    logic retire;
    logic ret_ok;
    logic sat;
    logic src_hazard;

`ifdef SB_FORWARDING_EN
    always_comb begin
        src_hazard = load_v_q && ((src1_en && (src1 == load_dest_q)) ||
                                  (two_src && (src2 == load_dest_q)));
    end
`else
    logic busy1;
    logic busy2;
    logic load_unused;

    // The register file writes on negedge, so the last pending write retiring this cycle is already readable.
    always_comb begin
        busy1 = (cnt[src1] != 2'd0) &&
                !((cnt[src1] == 2'd1) && wb_en && (dest_wb == src1));
        busy2 = (cnt[src2] != 2'd0) &&
                !((cnt[src2] == 2'd1) && wb_en && (dest_wb == src2));
        src_hazard = (src1_en && busy1) || (two_src && busy2);
    end

    assign load_unused = load_v_q ^ (^load_dest_q);
`endif

    // Saturation is judged on the pre-retire count: a same-cycle retire does not free a slot.
    always_comb begin
        sat    = issue_wb_en && (cnt[issue_dest] == MAX_CNT);
        hazard = !rst && issue_valid && (src_hazard || sat);
        accept = issue_valid && issue_wb_en && !hazard && !freeze && !flush;
        retire = wb_en && !freeze;
        ret_ok = retire && (cnt[dest_wb] != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                cnt[r] <= 2'd0;
            end
            load_v_q    <= 1'b0;
            load_dest_q <= 4'd0;
            pending_cnt <= 6'd0;
            sb_error    <= 1'b0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                if (accept && (issue_dest == 4'(r)) && !(ret_ok && (dest_wb == 4'(r)))) begin
                    cnt[r] <= cnt[r] + 2'd1;
                end else if (ret_ok && (dest_wb == 4'(r)) && !(accept && (issue_dest == 4'(r)))) begin
                    cnt[r] <= cnt[r] - 2'd1;
                end
            end

            if (accept && !ret_ok) begin
                pending_cnt <= pending_cnt + 6'd1;
            end else if (!accept && ret_ok) begin
                pending_cnt <= pending_cnt - 6'd1;
            end

            if (retire && (cnt[dest_wb] == 2'd0)) begin
                sb_error <= 1'b1;
            end

            if (!freeze) begin
                load_v_q <= accept && issue_is_load;
                if (accept) begin
                    load_dest_q <= issue_dest;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic against a reference model.
module tb_reg_scoreboard;

    localparam int MAX_PEND = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid, issue_wb_en, issue_is_load;
    logic [3:0] issue_dest, src1, src2, dest_wb;
    logic       src1_en, two_src, freeze, flush, wb_en;
    logic       hazard;
    logic [5:0] pending_cnt;
    logic       sb_error;

    int vec  = 0;
    int errs = 0;

    // reference model state
    int m_cnt [16];
    bit m_load_v;
    int m_load_dest;
    bit m_err;

    always #5 clk = ~clk;

    reg_scoreboard #(.MAX_PEND(MAX_PEND)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
        .issue_is_load(issue_is_load), .src1(src1), .src1_en(src1_en), .src2(src2),
        .two_src(two_src), .freeze(freeze), .flush(flush), .wb_en(wb_en), .dest_wb(dest_wb),
        .hazard(hazard), .pending_cnt(pending_cnt), .sb_error(sb_error)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic idle();
        issue_valid = 0; issue_wb_en = 0; issue_dest = 0; issue_is_load = 0;
        src1 = 0; src1_en = 0; src2 = 0; two_src = 0;
        freeze = 0; flush = 0; wb_en = 0; dest_wb = 0;
    endtask

    task automatic writer(input int d);
        idle();
        issue_valid = 1; issue_wb_en = 1; issue_dest = 4'(d);
    endtask

    // Non-writing reader of r: hazard reflects whether r still has a pending write.
    task automatic reader(input int r);
        idle();
        issue_valid = 1; src1 = 4'(r); src1_en = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        #1;
        vec++; if (pending_cnt !== 6'd0) begin errs++; $display("FAIL reset_pending: got %0d expected 0", pending_cnt); end
        vec++; if (sb_error !== 1'b0) begin errs++; $display("FAIL reset_sb_error: got %b expected 0", sb_error); end
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
        @(negedge clk);
        rst = 0;
        writer(3);
        @(negedge clk);
        @(negedge clk);
        idle();
        vec++; if (pending_cnt !== 6'd2) begin errs++; $display("FAIL midrst_pending_before: got %0d expected 2", pending_cnt); end
        reader(3);
        #1;
`ifndef SB_FORWARDING_EN
        vec++; if (hazard !== 1'b1) begin errs++; $display("FAIL midrst_hazard_before: got %b expected 1", hazard); end
`endif
        #1 rst = 1;
        #1;
        vec++; if (pending_cnt !== 6'd0) begin errs++; $display("FAIL midrst_pending: got %0d expected 0", pending_cnt); end
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL midrst_hazard: got %b expected 0", hazard); end
        @(negedge clk);
        rst = 0;
        #1;
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL postrst_hazard: got %b expected 0", hazard); end
        idle();
    endtask

    task automatic test_dependent();
        do_reset();
        writer(1); src1 = 2; src1_en = 1; src2 = 3; two_src = 1;
        #1;
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL dep_producer_hazard: got %b expected 0", hazard); end
        @(negedge clk);
        writer(1); src1 = 1; src1_en = 1;
        #1;
`ifndef SB_FORWARDING_EN
        vec++; if (hazard !== 1'b1) begin errs++; $display("FAIL dep_n1_hazard: got %b expected 1", hazard); end
        @(negedge clk); #1;
        vec++; if (hazard !== 1'b1) begin errs++; $display("FAIL dep_n2_hazard: got %b expected 1", hazard); end
        @(negedge clk);
        wb_en = 1; dest_wb = 1;
        #1;
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL dep_n3_hazard: got %b expected 0", hazard); end
        @(negedge clk);
        idle();
        vec++; if (pending_cnt !== 6'd1) begin errs++; $display("FAIL dep_pending: got %0d expected 1", pending_cnt); end
        reader(1); #1;
        vec++; if (hazard !== 1'b1) begin errs++; $display("FAIL dep_r1_still_busy: got %b expected 1", hazard); end
        idle();
`else
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL fwd_n1_hazard: got %b expected 0", hazard); end
        @(negedge clk);
        idle();
        vec++; if (pending_cnt !== 6'd2) begin errs++; $display("FAIL fwd_pending: got %0d expected 2", pending_cnt); end
        do_reset();
        writer(1); issue_is_load = 1;
        @(negedge clk);
        writer(2); src1 = 1; src1_en = 1;
        #1;
        vec++; if (hazard !== 1'b1) begin errs++; $display("FAIL fwd_loaduse_n1: got %b expected 1", hazard); end
        @(negedge clk); #1;
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL fwd_loaduse_n2: got %b expected 0", hazard); end
        @(negedge clk);
        idle();
        vec++; if (pending_cnt !== 6'd2) begin errs++; $display("FAIL fwd_load_pending: got %0d expected 2", pending_cnt); end
`endif
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            writer(5); #1;
            vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL sat_fill%0d_hazard: got %b expected 0", k, hazard); end
            @(negedge clk);
        end
        writer(5); wb_en = 1; dest_wb = 5;
        #1;
        vec++; if (hazard !== 1'b1) begin errs++; $display("FAIL sat_full_hazard: got %b expected 1", hazard); end
        @(negedge clk);
        wb_en = 0;
        vec++; if (pending_cnt !== 6'd2) begin errs++; $display("FAIL sat_after_retire_pending: got %0d expected 2", pending_cnt); end
        #1;
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL sat_reissue_hazard: got %b expected 0", hazard); end
        @(negedge clk);
        idle();
        vec++; if (pending_cnt !== 6'd3) begin errs++; $display("FAIL sat_final_pending: got %0d expected 3", pending_cnt); end
        writer(5); flush = 1; #1;
        vec++; if (hazard !== 1'b1) begin errs++; $display("FAIL sat_cnt5_full: got %b expected 1", hazard); end
        idle();
    endtask

    task automatic test_same_cycle();
        do_reset();
        writer(7);
        @(negedge clk);
        vec++; if (pending_cnt !== 6'd1) begin errs++; $display("FAIL same_setup_pending: got %0d expected 1", pending_cnt); end
        writer(7); wb_en = 1; dest_wb = 7;
        #1;
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL same_hazard: got %b expected 0", hazard); end
        @(negedge clk);
        idle();
        vec++; if (pending_cnt !== 6'd1) begin errs++; $display("FAIL same_pending: got %0d expected 1", pending_cnt); end
        vec++; if (sb_error !== 1'b0) begin errs++; $display("FAIL same_sb_error: got %b expected 0", sb_error); end
`ifndef SB_FORWARDING_EN
        reader(7); #1;
        vec++; if (hazard !== 1'b1) begin errs++; $display("FAIL same_r7_busy: got %b expected 1", hazard); end
`endif
        idle(); wb_en = 1; dest_wb = 9;
        @(negedge clk);
        idle();
        vec++; if (sb_error !== 1'b1) begin errs++; $display("FAIL underflow_sb_error: got %b expected 1", sb_error); end
        vec++; if (pending_cnt !== 6'd1) begin errs++; $display("FAIL underflow_pending: got %0d expected 1", pending_cnt); end
    endtask

    task automatic test_freeze_flush();
        do_reset();
        writer(4);
        @(negedge clk);
        writer(6); wb_en = 1; dest_wb = 4; freeze = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL freeze%0d_hazard: got %b expected 0", k, hazard); end
            @(negedge clk);
            vec++; if (pending_cnt !== 6'd1) begin errs++; $display("FAIL freeze%0d_pending: got %0d expected 1", k, pending_cnt); end
        end
        idle();
`ifndef SB_FORWARDING_EN
        reader(4); #1;
        vec++; if (hazard !== 1'b1) begin errs++; $display("FAIL freeze_r4_busy: got %b expected 1", hazard); end
        reader(6); #1;
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL freeze_r6_free: got %b expected 0", hazard); end
`endif
        writer(6); flush = 1; #1;
        vec++; if (hazard !== 1'b0) begin errs++; $display("FAIL flush_hazard: got %b expected 0", hazard); end
        @(negedge clk);
        idle();
        vec++; if (pending_cnt !== 6'd1) begin errs++; $display("FAIL flush_pending: got %0d expected 1", pending_cnt); end
        vec++; if (sb_error !== 1'b0) begin errs++; $display("FAIL freeze_flush_sb_error: got %b expected 0", sb_error); end
    endtask

    // A source is unavailable while a write to it is outstanding, unless the only one is writing back right now.
    function automatic bit m_busy(input logic [3:0] s);
        return (m_cnt[s] > 0) && !(m_cnt[s] == 1 && wb_en && dest_wb == s);
    endfunction

    function automatic bit m_hazard();
        bit src_h, sat_h;
`ifdef SB_FORWARDING_EN
        src_h = m_load_v && ((src1_en && int'(src1) == m_load_dest) || (two_src && int'(src2) == m_load_dest));
`else
        src_h = (src1_en && m_busy(src1)) || (two_src && m_busy(src2));
`endif
        sat_h = issue_wb_en && (m_cnt[issue_dest] == MAX_PEND);
        return issue_valid && (src_h || sat_h);
    endfunction

    task automatic test_random();
        bit exp_h, acc, ret;
        int pre, sum, start;
        do_reset();
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_load_v = 0; m_load_dest = 0; m_err = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            issue_valid   = ($urandom % 4) != 0;
            issue_wb_en   = ($urandom % 4) != 0;
            issue_dest    = 4'($urandom_range(5, 0));
            issue_is_load = ($urandom % 3) == 0;
            src1          = 4'($urandom_range(5, 0));
            src1_en       = ($urandom % 4) != 0;
            src2          = 4'($urandom_range(5, 0));
            two_src       = ($urandom % 2) != 0;
            freeze        = ($urandom % 8) == 0;
            flush         = ($urandom % 8) == 0;
            wb_en         = ($urandom % 2) != 0;
            dest_wb       = 4'($urandom_range(15, 0));
            if (($urandom % 24) != 0) begin
                start = $urandom_range(15, 0);
                for (int i = 15; i >= 0; i--)
                    if (m_cnt[(start + i) % 16] > 0) dest_wb = 4'((start + i) % 16);
            end
            #1;
            exp_h = m_hazard();
            vec++; if (hazard !== exp_h) begin errs++; $display("FAIL rand_hazard cyc %0d: got %b expected %b", cyc, hazard, exp_h); end
            acc = issue_valid && issue_wb_en && !exp_h && !freeze && !flush;
            ret = wb_en && !freeze;
            @(negedge clk);
            pre = m_cnt[dest_wb];
            if (!freeze) begin
                if (acc) m_cnt[issue_dest] = m_cnt[issue_dest] + 1;
                if (ret && pre > 0) m_cnt[dest_wb] = m_cnt[dest_wb] - 1;
                if (ret && pre == 0) m_err = 1;
                m_load_v = acc && issue_is_load;
                if (acc) m_load_dest = int'(issue_dest);
            end
            sum = 0;
            for (int r = 0; r < 16; r++) sum += m_cnt[r];
            vec++; if (int'(pending_cnt) != sum) begin errs++; $display("FAIL rand_pending cyc %0d: got %0d expected %0d", cyc, pending_cnt, sum); end
            vec++; if (sb_error !== m_err) begin errs++; $display("FAIL rand_sb_error cyc %0d: got %b expected %b", cyc, sb_error, m_err); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_dependent();
        test_saturation();
        test_same_cycle();
        test_freeze_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
